// File: rtl/rx_ltssm_pkg.sv
// Symbol constants and lane-checker encodings shared by the RX ordered-set
// checker and the master RX LTSSM.
package rx_ltssm_pkg;

    localparam int OS_LEN = 16;

    localparam logic [7:0] TS1_ID   = 8'h1E;
    localparam logic [7:0] TS2_ID   = 8'h2D;
    localparam logic [7:0] TS1_FILL = 8'h4A;
    localparam logic [7:0] TS2_FILL = 8'h45;

    localparam logic [3:0] COUNT_SAT = 4'd15;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } lane_state_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] value);
        return (value == COUNT_SAT) ? COUNT_SAT : value + 4'd1;
    endfunction

endpackage

// File: rtl/rx_os_lane_checker.sv
// Single-lane TS1/TS2 ordered-set parser: collects one OS, validates it and
// counts consecutive identical sets of the expected type.
module rx_os_lane_checker #(
    parameter int OS_LEN  = rx_ltssm_pkg::OS_LEN,
    parameter bit RATE_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sym,
    input  logic       valid,
    input  logic       os_start,
    input  logic       expect_ts2,
    input  logic       clear,
    output logic [3:0] count,
    output logic [7:0] link_num,
    output logic [7:0] lane_num,
    output logic [7:0] rate_id,
    output logic       os_error
);
    import rx_ltssm_pkg::*;

    localparam int IDX_W = $clog2(OS_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OS_LEN - 1);

    lane_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx;
    logic [7:0]       sym0;
    logic [4:0][7:0]  cur;
    logic [4:0][7:0]  prv;
    logic             fill1_ok, fill2_ok;
    logic             start, accept, last;
    logic             id_ok, fill_ok, os_valid, same;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        accept  = 1'b0;
        last    = 1'b0;
        if (clear) begin
            state_d = IDLE;
        end else if (valid) begin
            // A start marker always begins a fresh OS, abandoning any partial one.
            if (os_start) begin
                start   = 1'b1;
                state_d = COLLECT;
            end else if (state_q == COLLECT) begin
                accept = 1'b1;
                if (idx == LAST_IDX) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
        end
    end

    // Both fill flags are tracked so expectTs2 only matters at the final symbol.
    assign id_ok    = (sym0 == (expect_ts2 ? TS2_ID : TS1_ID));
    assign fill_ok  = expect_ts2 ? (fill2_ok && (sym == TS2_FILL))
                                 : (fill1_ok && (sym == TS1_FILL));
    assign os_valid = id_ok && fill_ok;
    assign same     = (cur == prv) && (count != 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx      <= '0;
            sym0     <= 8'h00;
            cur      <= '0;
            prv      <= '0;
            fill1_ok <= 1'b0;
            fill2_ok <= 1'b0;
            count    <= 4'd0;
            link_num <= 8'h00;
            lane_num <= 8'h00;
            rate_id  <= 8'h00;
            os_error <= 1'b0;
        end else begin
            os_error <= 1'b0;
            if (clear) begin
                idx   <= '0;
                prv   <= '0;
                count <= 4'd0;
            end else if (start) begin
                sym0     <= sym;
                idx      <= IDX_W'(1);
                fill1_ok <= 1'b1;
                fill2_ok <= 1'b1;
            end else if (accept) begin
                idx <= idx + IDX_W'(1);
                for (int k = 0; k < 5; k++) begin
                    if (idx == IDX_W'(k + 1)) cur[k] <= sym;
                end
                if (idx > IDX_W'(5)) begin
                    fill1_ok <= fill1_ok && (sym == TS1_FILL);
                    fill2_ok <= fill2_ok && (sym == TS2_FILL);
                end
                if (last) begin
                    if (os_valid) begin
                        count    <= same ? sat_inc(count) : 4'd1;
                        prv      <= cur;
                        link_num <= cur[0];
                        lane_num <= cur[1];
                        if (RATE_EN) rate_id <= cur[3];
                    end else begin
                        count    <= 4'd0;
                        os_error <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rx_os_checker.sv
// Multi-lane TS ordered-set checker feeding the RX LTSSM; one independent
// lane checker per lane, outputs packed per lane.
module rx_os_checker #(
    parameter int MAXLANES = 16,
    parameter int OS_LEN   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8*MAXLANES-1:0] rxData,
    input  logic [MAXLANES-1:0]   rxValid,
    input  logic [MAXLANES-1:0]   rxOsStart,
    input  logic                  expectTs2,
    input  logic [15:0]           resetOsCheckers,
    output logic [4*MAXLANES-1:0] countersValues,
    output logic [8*MAXLANES-1:0] linkNum,
    output logic [8*MAXLANES-1:0] laneNum,
    output logic [7:0]            rateId,
    output logic [MAXLANES-1:0]   osError
);

    logic [7:0] rate_lane [MAXLANES];

    for (genvar i = 0; i < MAXLANES; i++) begin : g_lane
        rx_os_lane_checker #(
            .OS_LEN (OS_LEN),
            .RATE_EN(i == 0)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .sym       (rxData[8*i +: 8]),
            .valid     (rxValid[i]),
            .os_start  (rxOsStart[i]),
            .expect_ts2(expectTs2),
            .clear     (resetOsCheckers[i]),
            .count     (countersValues[4*i +: 4]),
            .link_num  (linkNum[8*i +: 8]),
            .lane_num  (laneNum[8*i +: 8]),
            .rate_id   (rate_lane[i]),
            .os_error  (osError[i])
        );
    end

    // Only lane 0 captures a rate; the other lanes hold zero, so the OR is lane 0.
    always_comb begin
        rateId = 8'h00;
        for (int i = 0; i < MAXLANES; i++) rateId = rateId | rate_lane[i];
    end

endmodule

// File: tb/tb_rx_os_checker.sv
// Directed bench for rx_os_checker: counting, field changes, invalid sets,
// saturation, per-lane clears, gaps and aborts, asynchronous reset.
module tb_rx_os_checker;

    typedef logic [7:0] os_t [16];

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] rxData;
    logic [15:0]  rxValid;
    logic [15:0]  rxOsStart;
    logic         expectTs2;
    logic [15:0]  resetOsCheckers;
    logic [63:0]  countersValues;
    logic [127:0] linkNum;
    logic [127:0] laneNum;
    logic [7:0]   rateId;
    logic [15:0]  osError;

    int checks = 0;
    int errors = 0;
    logic [15:0] err_seen;

    rx_os_checker #(.MAXLANES(16), .OS_LEN(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .rxData         (rxData),
        .rxValid        (rxValid),
        .rxOsStart      (rxOsStart),
        .expectTs2      (expectTs2),
        .resetOsCheckers(resetOsCheckers),
        .countersValues (countersValues),
        .linkNum        (linkNum),
        .laneNum        (laneNum),
        .rateId         (rateId),
        .osError        (osError)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic os_t mk_os(input bit ts2, input logic [7:0] link, input logic [7:0] lane,
                                  input logic [7:0] nfts, input logic [7:0] rate);
        os_t o;
        o[0] = ts2 ? 8'h2D : 8'h1E;
        o[1] = link;
        o[2] = lane;
        o[3] = nfts;
        o[4] = rate;
        o[5] = 8'h00;
        for (int k = 6; k < 16; k++) o[k] = ts2 ? 8'h45 : 8'h4A;
        return o;
    endfunction

    task automatic drive_sym(input logic [15:0] mask, input logic [7:0] s, input bit st);
        for (int l = 0; l < 16; l++) rxData[8*l +: 8] = mask[l] ? s : 8'h00;
        rxValid   = mask;
        rxOsStart = st ? mask : 16'h0;
        @(posedge clk); #1;
        rxValid   = 16'h0;
        rxOsStart = 16'h0;
        err_seen  = err_seen | osError;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            err_seen = err_seen | osError;
        end
    endtask

    task automatic send_os(input logic [15:0] mask, input os_t o, input int gap);
        for (int i = 0; i < 16; i++) begin
            drive_sym(mask, o[i], i == 0);
            if (gap > 0 && i < 15) idle_cycles(gap);
        end
    endtask

    task automatic clear_lanes(input logic [15:0] mask);
        resetOsCheckers = mask;
        @(posedge clk); #1;
        resetOsCheckers = 16'h0;
        err_seen = 16'h0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        rxData = '0; rxValid = '0; rxOsStart = '0;
        expectTs2 = 1'b0; resetOsCheckers = '0; err_seen = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (countersValues !== 64'h0) begin
            errors++; $display("FAIL reset_count: got %h want 0", countersValues);
        end
        checks++;
        if (linkNum !== 128'h0 || laneNum !== 128'h0) begin
            errors++; $display("FAIL reset_fields: link %h lane %h want 0", linkNum, laneNum);
        end
        checks++;
        if (rateId !== 8'h00 || osError !== 16'h0) begin
            errors++; $display("FAIL reset_rate_err: rate %h err %h want 0", rateId, osError);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ts1_count;
        os_t o;
        clear_lanes(16'h0001);
        expectTs2 = 1'b0;
        o = mk_os(1'b0, 8'hF7, 8'hF7, 8'h10, 8'h02);
        for (int k = 1; k <= 8; k++) begin
            send_os(16'h0001, o, 0);
            checks++;
            if (countersValues[3:0] !== 4'(k)) begin
                errors++; $display("FAIL ts1_count_%0d: got %0d want %0d", k, countersValues[3:0], k);
            end
        end
        checks++;
        if (rateId !== 8'h02 || linkNum[7:0] !== 8'hF7 || laneNum[7:0] !== 8'hF7) begin
            errors++; $display("FAIL ts1_fields: rate %h link %h lane %h want 02 f7 f7",
                               rateId, linkNum[7:0], laneNum[7:0]);
        end
        checks++;
        if (err_seen[0] !== 1'b0) begin
            errors++; $display("FAIL ts1_no_error: got %b want 0", err_seen[0]);
        end
    endtask

    task automatic test_field_change;
        os_t o, o2, o3;
        clear_lanes(16'h0001);
        o  = mk_os(1'b0, 8'h01, 8'h00, 8'h10, 8'h02);
        o2 = mk_os(1'b0, 8'h01, 8'h00, 8'h20, 8'h02);
        o3 = mk_os(1'b0, 8'h05, 8'h00, 8'h20, 8'h02);
        for (int k = 1; k <= 3; k++) begin
            send_os(16'h0001, o, 0);
            checks++;
            if (countersValues[3:0] !== 4'(k)) begin
                errors++; $display("FAIL field_pre_%0d: got %0d want %0d", k, countersValues[3:0], k);
            end
        end
        send_os(16'h0001, o2, 0);
        checks++;
        if (countersValues[3:0] !== 4'd1) begin
            errors++; $display("FAIL field_sym3_change: got %0d want 1", countersValues[3:0]);
        end
        send_os(16'h0001, o3, 0);
        checks++;
        if (countersValues[3:0] !== 4'd1 || linkNum[7:0] !== 8'h05) begin
            errors++; $display("FAIL field_link_change: count %0d link %h want 1 05",
                               countersValues[3:0], linkNum[7:0]);
        end
        send_os(16'h0001, o3, 0);
        checks++;
        if (countersValues[3:0] !== 4'd2 || err_seen[0] !== 1'b0) begin
            errors++; $display("FAIL field_repeat: count %0d err %b want 2 0",
                               countersValues[3:0], err_seen[0]);
        end
    endtask

    task automatic test_invalid;
        os_t o, bad;
        clear_lanes(16'h0001);
        o = mk_os(1'b0, 8'h03, 8'h01, 8'h10, 8'h02);
        bad = o;
        bad[9] = 8'h00;
        repeat (5) send_os(16'h0001, o, 0);
        checks++;
        if (countersValues[3:0] !== 4'd5) begin
            errors++; $display("FAIL invalid_pre: got %0d want 5", countersValues[3:0]);
        end
        send_os(16'h0001, bad, 0);
        checks++;
        if (countersValues[3:0] !== 4'd0 || osError[0] !== 1'b1) begin
            errors++; $display("FAIL invalid_os: count %0d err %b want 0 1",
                               countersValues[3:0], osError[0]);
        end
        idle_cycles(1);
        checks++;
        if (osError[0] !== 1'b0) begin
            errors++; $display("FAIL invalid_pulse_width: got %b want 0", osError[0]);
        end
        send_os(16'h0001, o, 0);
        checks++;
        if (countersValues[3:0] !== 4'd1) begin
            errors++; $display("FAIL invalid_recover: got %0d want 1", countersValues[3:0]);
        end
    endtask

    task automatic test_saturate;
        os_t t, o;
        clear_lanes(16'h0001);
        expectTs2 = 1'b1;
        t = mk_os(1'b1, 8'h07, 8'h00, 8'h10, 8'h03);
        o = mk_os(1'b0, 8'h07, 8'h00, 8'h10, 8'h03);
        for (int k = 1; k <= 20; k++) begin
            send_os(16'h0001, t, 0);
            checks++;
            if (countersValues[3:0] !== ((k > 15) ? 4'd15 : 4'(k))) begin
                errors++; $display("FAIL saturate_%0d: got %0d want %0d", k, countersValues[3:0],
                                   (k > 15) ? 15 : k);
            end
        end
        send_os(16'h0001, o, 0);
        checks++;
        if (countersValues[3:0] !== 4'd0 || osError[0] !== 1'b1) begin
            errors++; $display("FAIL saturate_wrong_type: count %0d err %b want 0 1",
                               countersValues[3:0], osError[0]);
        end
        expectTs2 = 1'b0;
    endtask

    task automatic test_lane_clear;
        os_t o;
        clear_lanes(16'h0003);
        o = mk_os(1'b0, 8'h09, 8'h02, 8'h10, 8'h02);
        repeat (3) send_os(16'h0003, o, 0);
        for (int i = 0; i < 7; i++) drive_sym(16'h0003, o[i], i == 0);
        resetOsCheckers = 16'h0001;
        drive_sym(16'h0003, o[7], 1'b0);
        resetOsCheckers = 16'h0000;
        checks++;
        if (countersValues[3:0] !== 4'd0 || countersValues[7:4] !== 4'd3) begin
            errors++; $display("FAIL clear_immediate: lane0 %0d lane1 %0d want 0 3",
                               countersValues[3:0], countersValues[7:4]);
        end
        for (int i = 8; i < 16; i++) drive_sym(16'h0003, o[i], 1'b0);
        checks++;
        if (countersValues[3:0] !== 4'd0 || countersValues[7:4] !== 4'd4 || err_seen[1:0] !== 2'b00) begin
            errors++; $display("FAIL clear_rest_ignored: lane0 %0d lane1 %0d err %b want 0 4 00",
                               countersValues[3:0], countersValues[7:4], err_seen[1:0]);
        end
        checks++;
        if (linkNum[7:0] !== 8'h09) begin
            errors++; $display("FAIL clear_keeps_link: got %h want 09", linkNum[7:0]);
        end
        send_os(16'h0001, o, 0);
        checks++;
        if (countersValues[3:0] !== 4'd1) begin
            errors++; $display("FAIL clear_restart: got %0d want 1", countersValues[3:0]);
        end
    endtask

    task automatic test_gaps_abort;
        os_t o;
        clear_lanes(16'h0001);
        o = mk_os(1'b0, 8'h11, 8'h00, 8'h10, 8'h02);
        send_os(16'h0001, o, 3);
        checks++;
        if (countersValues[3:0] !== 4'd1) begin
            errors++; $display("FAIL gap_count: got %0d want 1", countersValues[3:0]);
        end
        for (int i = 0; i < 10; i++) begin
            drive_sym(16'h0001, o[i], i == 0);
            idle_cycles(3);
        end
        send_os(16'h0001, o, 3);
        checks++;
        if (countersValues[3:0] !== 4'd2 || err_seen[0] !== 1'b0) begin
            errors++; $display("FAIL abort_restart: count %0d err %b want 2 0",
                               countersValues[3:0], err_seen[0]);
        end
    endtask

    task automatic test_async_reset;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (countersValues[3:0] !== 4'd0 || linkNum[7:0] !== 8'h00 || rateId !== 8'h00) begin
            errors++; $display("FAIL async_reset: count %0d link %h rate %h want 0 00 00",
                               countersValues[3:0], linkNum[7:0], rateId);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_ts1_count();
        test_field_change();
        test_invalid();
        test_saturate();
        test_lane_clear();
        test_gaps_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
